// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter and its sub-blocks.
package shift_arb_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit logical barrel shifter, zero fill in both directions.
module barrel_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  output logic [DATA_W-1:0]  result
);

  assign result = (dir == DIR_RIGHT) ? (data >> shamt) : (data << shamt);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first request found after last_grant, wrapping.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  int               idx_int;
  logic [PTR_W-1:0] idx;

  // Offset N wraps back to last_grant itself, so a lone requester can win twice.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_int   = 0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx_int = (int'(last_grant) + k) % N;
      idx     = PTR_W'(idx_int);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Time-shares one barrel shifter between NUM_REQ requesters with round-robin
// arbitration and a registered valid/ready response.
//
// state | meaning
// IDLE  | offer req_ready to the round-robin winner, capture operands on handshake
// SHIFT | op registers drive the shifter; result registered at the edge
// HOLD  | rsp_valid high, result held until rsp_ready
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0]  req_shamt,
  input  logic [NUM_REQ-1:0]          req_dir,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        busy
);

  state_t               state, next_state;
  logic [ID_W-1:0]      last_grant, grant_idx, op_id;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_any;
  logic [DATA_W-1:0]    op_data, shift_out;
  logic [SHAMT_W-1:0]   op_shamt;
  logic                 op_dir;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  barrel_shifter u_shift (
    .data   (op_data),
    .shamt  (op_shamt),
    .dir    (op_dir),
    .result (shift_out)
  );

  // The grant is a subset of req_valid, so any grant in IDLE is a handshake.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = SHIFT;
      SHIFT:   next_state = HOLD;
      HOLD:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_data    <= '0;
      op_shamt   <= '0;
      op_dir     <= 1'b0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_data    <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            op_shamt   <= req_shamt[int'(grant_idx)*SHAMT_W +: SHAMT_W];
            op_dir     <= req_dir[grant_idx];
            op_id      <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        SHIFT: begin
          rsp_data  <= shift_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed corner cases then random traffic.
module tb_shift_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ*3-1:0] req_shamt;
  logic [NUM_REQ-1:0]   req_dir;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  shift_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_dir   (req_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic shift and a rotating priority search.
  function automatic logic [7:0] model_shift(input logic [7:0] d, input int s, input logic dr);
    int x;
    x = int'(d);
    if (dr) x = x / (1 << s);
    else    x = (x * (1 << s)) % 256;
    return 8'(x);
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  typedef struct { int id; int data; int hs; } exp_t;
  exp_t            sb[$];
  int              ptr_m = NUM_REQ - 1;
  bit              shown = 1'b0;
  logic [7:0]      held_data;
  logic [ID_W-1:0] held_id;
  logic [NUM_REQ-1:0] mon_hs;
  int              pick;
  exp_t            e;

  // Monitor: predicts at request handshake, compares when a response shows up.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      ptr_m = NUM_REQ - 1;
      shown = 1'b0;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
    end else begin
      chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
      if (busy) chk("ready_while_busy", int'(req_ready), 0);
      mon_hs = req_valid & req_ready;
      if (mon_hs != '0) begin
        pick = model_pick(req_valid, ptr_m);
        chk("grant_onehot", int'(mon_hs), 1 << pick);
        e.id   = pick;
        e.data = int'(model_shift(req_data[pick*8 +: 8], int'(req_shamt[pick*3 +: 3]), req_dir[pick]));
        e.hs   = cyc;
        sb.push_back(e);
        ptr_m = pick;
      end
      if (rsp_valid) begin
        if (!shown) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected no response", rsp_id, rsp_data);
          end else begin
            chk("rsp_latency", cyc, sb[0].hs + 2);
            chk("rsp_data", int'(rsp_data), sb[0].data);
            chk("rsp_id", int'(rsp_id), sb[0].id);
          end
          chk("busy_in_hold", int'(busy), 1);
          shown     = 1'b1;
          held_data = rsp_data;
          held_id   = rsp_id;
        end else begin
          chk("hold_data_stable", int'(rsp_data), int'(held_data));
          chk("hold_id_stable", int'(rsp_id), int'(held_id));
        end
        if (rsp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          shown = 1'b0;
        end
      end else if (shown) begin
        checks++;
        failures++;
        $display("FAIL rsp_dropped: got rsp_valid 0 expected 1 before rsp_ready");
        shown = 1'b0;
      end
    end
  end

  task automatic raise(input int i, input logic [7:0] d, input logic [2:0] s, input logic dr);
    req_data[i*8 +: 8]  = d;
    req_shamt[i*3 +: 3] = s;
    req_dir[i]          = dr;
    req_valid[i]        = 1'b1;
  endtask

  // One cycle: note handshakes at the negedge, drop those valids after the edge.
  task automatic tick(output logic [NUM_REQ-1:0] taken);
    @(negedge clk);
    taken = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~taken;
  endtask

  task automatic wait_taken(input int i, input string name);
    logic [NUM_REQ-1:0] t;
    for (int n = 0; n < 30; n++) begin
      tick(t);
      if (t[i]) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: got no grant for requester %0d expected one within 30 cycles", name, i);
  endtask

  task automatic drain(input string name);
    logic [NUM_REQ-1:0] t;
    rsp_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (req_valid == '0 && !busy && !rsp_valid) return;
      tick(t);
    end
    checks++;
    failures++;
    $display("FAIL %s: got still busy expected idle within 100 cycles", name);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic single(input int i, input logic [7:0] d, input logic [2:0] s,
                        input logic dr, input int exp, input string name);
    raise(i, d, s, dr);
    rsp_ready = 1'b1;
    wait_taken(i, {name, "_grant"});
    chk({name, "_busy_shift"}, int'(busy), 1);
    chk({name, "_valid_shift"}, int'(rsp_valid), 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, int'(rsp_valid), 1);
    chk({name, "_data"}, int'(rsp_data), exp);
    chk({name, "_id"}, int'(rsp_id), i);
    chk({name, "_busy_hold"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({name, "_valid_after"}, int'(rsp_valid), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  logic [NUM_REQ-1:0] t;
  int gorder[$];
  int gcyc[$];
  logic [7:0] sd;
  logic [ID_W-1:0] sid;

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_dir   = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_busy", int'(busy), 0);
    do_reset();

    single(0, 8'hB5, 3'd3, 1'b0, 8'hA8, "left_b5_3");
    single(2, 8'hB5, 3'd3, 1'b1, 8'h16, "right_b5_3");
    single(1, 8'h5A, 3'd0, 1'b0, 8'h5A, "shamt0");
    single(3, 8'hFF, 3'd7, 1'b0, 8'h80, "left_ff_7");
    single(0, 8'hFF, 3'd7, 1'b1, 8'h01, "right_ff_7");

    // All requesters held valid: strict rotation, one result per 3 cycles.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) raise(i, 8'($urandom), 3'($urandom), 1'($urandom));
    for (int n = 0; n < 40 && gorder.size() < 5; n++) begin
      tick(t);
      for (int i = 0; i < NUM_REQ; i++)
        if (t[i]) begin
          gorder.push_back(i);
          gcyc.push_back(cyc);
          raise(i, 8'($urandom), 3'($urandom), 1'($urandom));
        end
    end
    chk("rotation_count", gorder.size(), 5);
    for (int k = 0; k < gorder.size(); k++) chk("rotation_order", gorder[k], k % NUM_REQ);
    for (int k = 1; k < gcyc.size(); k++) chk("rotation_interval", gcyc[k] - gcyc[k-1], 3);
    drain("rotation_drain");

    // Backpressure in HOLD with another requester waiting.
    rsp_ready = 1'b0;
    raise(3, 8'hC3, 3'd2, 1'b1);
    wait_taken(3, "bp_grant");
    raise(1, 8'h81, 3'd1, 1'b0);
    @(posedge clk); #1;
    sd  = rsp_data;
    sid = rsp_id;
    chk("bp_data", int'(sd), 8'h30);
    chk("bp_id", int'(sid), 3);
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_data_stable", int'(rsp_data), int'(sd));
      chk("bp_id_stable", int'(rsp_id), int'(sid));
      chk("bp_ready_low", int'(req_ready), 0);
      chk("bp_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", int'(rsp_valid), 0);
    chk("bp_released_busy", int'(busy), 0);
    chk("bp_next_grant", int'(req_ready), 4'b0010);
    drain("bp_drain");

    // Reset while HOLD: rsp_valid must fall without waiting for a clock.
    rsp_ready = 1'b0;
    raise(2, 8'h0F, 3'd1, 1'b0);
    wait_taken(2, "rst_hold_grant");
    @(posedge clk); #1;
    chk("rst_hold_pre_valid", int'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_async_valid", int'(rsp_valid), 0);
    chk("rst_hold_async_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during SHIFT for requester 1: no response, pointer back to 0.
    rsp_ready = 1'b1;
    raise(1, 8'h3C, 3'd2, 1'b0);
    wait_taken(1, "rst_shift_grant");
    rst = 1'b1;
    #1;
    chk("rst_shift_valid", int'(rsp_valid), 0);
    chk("rst_shift_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    raise(0, 8'h11, 3'd1, 1'b0);
    raise(1, 8'h22, 3'd1, 1'b1);
    tick(t);
    chk("rst_priority", int'(t), 4'b0001);
    drain("rst_drain");

    // Random traffic against the scoreboard.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      tick(t);
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          raise(i, 8'($urandom), 3'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain("random_drain");
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
